fetch_sequencer: RTL and testbench

Instruction-fetch control FSM for the 19-bit CPU. It drives the program counter's command inputs (LOAD_REG, LOAD_SELECT, INC_PC, load address) and the instruction-memory read handshake, and it holds the fetched instruction for the execute stage. On an execute-done/branch report it either increments the PC or loads a branch target. It sits between the control bus, the address bus and instruction memory, with no other owner of PC commands.

---
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control FSM for the 19-bit CPU.
// Drives PC commands and the imem read handshake; holds INSTR for execute.
module fetch_sequencer #(
   parameter int         AW       = 19,
   parameter int         DW       = 19,
   parameter logic [1:0] SEL_PC   = 2'b01,
   parameter logic [1:0] SEL_NONE = 2'b00,
   parameter int         TIMEOUT  = 16
) (
   input  logic          CLK,
   input  logic          RESET_N,
   input  logic          START,
   input  logic          HALT_REQ,
   output logic          MEM_RD_REQ,
   input  logic          MEM_RD_ACK,
   input  logic [DW-1:0] MEM_RDATA,
   output logic [DW-1:0] INSTR,
   output logic          INSTR_VALID,
   input  logic          EXEC_DONE,
   input  logic          BRANCH_TAKEN,
   input  logic [AW-1:0] BRANCH_TARGET,
   output logic          LOAD_REG,
   output logic [1:0]    LOAD_SELECT,
   output logic          INC_PC,
   output logic [AW-1:0] PC_LOAD_ADDR,
   output logic          HALTED,
   output logic          FETCH_ERR,
   output logic [2:0]    STATE
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_FETCH  = 3'd2,
      S_EXEC   = 3'd3,
      S_UPDATE = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

   state_t        state;
   state_t        state_nx;
   logic [7:0]    wcnt;
   logic          tmo;
   logic          first_q;
   logic          br_q;
   logic          hpend_q;
   logic          err_q;
   logic [DW-1:0] instr_q;
   logic [AW-1:0] addr_q;

   assign tmo          = (wcnt == TLAST);
   assign INSTR        = instr_q;
   assign PC_LOAD_ADDR = addr_q;
   assign FETCH_ERR    = err_q;
   assign STATE        = state;

   // state register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= S_IDLE;
      else          state <= state_nx;
   end

   // next state and Moore command/handshake outputs
   always_comb begin
      state_nx    = state;
      LOAD_SELECT = SEL_NONE;
      LOAD_REG    = 1'b0;
      INC_PC      = 1'b0;
      MEM_RD_REQ  = 1'b0;
      INSTR_VALID = 1'b0;
      HALTED      = 1'b0;
      case (state)
         S_IDLE: begin
            if (START) state_nx = S_CLEAR;
         end
         S_CLEAR: begin
            LOAD_SELECT = SEL_PC;
            state_nx    = S_FETCH;
         end
         S_FETCH: begin
            MEM_RD_REQ = 1'b1;
            if (MEM_RD_ACK) state_nx = S_EXEC;
            else if (tmo)   state_nx = S_HALT;
         end
         S_EXEC: begin
            INSTR_VALID = first_q;
            if (EXEC_DONE) state_nx = S_UPDATE;
         end
         S_UPDATE: begin
            LOAD_SELECT = SEL_PC;
            LOAD_REG    = br_q;
            INC_PC      = ~br_q;
            if (hpend_q || HALT_REQ) state_nx = S_HALT;
            else                     state_nx = S_FETCH;
         end
         S_HALT: begin
            HALTED = 1'b1;
            if (START) state_nx = S_CLEAR;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // fetch wait counter, restarts on every FETCH entry
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         wcnt <= '0;
      else if (state == S_FETCH && state_nx == S_FETCH)
         wcnt <= wcnt + 8'd1;
      else
         wcnt <= '0;
   end

   // instruction capture and first-EXEC-cycle marker
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         instr_q <= '0;
         first_q <= 1'b0;
      end else begin
         first_q <= (state == S_FETCH) && MEM_RD_ACK;
         if (state == S_FETCH && MEM_RD_ACK)
            instr_q <= MEM_RDATA;
      end
   end

   // branch report latched at end of execute
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         br_q   <= 1'b0;
         addr_q <= '0;
      end else if (state == S_EXEC && EXEC_DONE) begin
         br_q   <= BRANCH_TAKEN;
         addr_q <= BRANCH_TARGET;
      end
   end

   // sticky halt request, honoured at the next instruction boundary
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         hpend_q <= 1'b0;
      else if (state == S_CLEAR)
         hpend_q <= 1'b0;
      else if (HALT_REQ &&
               (state == S_FETCH || state == S_EXEC || state == S_UPDATE))
         hpend_q <= 1'b1;
   end

   // sticky fetch timeout flag
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         err_q <= 1'b0;
      else if (state == S_CLEAR)
         err_q <= 1'b0;
      else if (state == S_FETCH && !MEM_RD_ACK && tmo)
         err_q <= 1'b1;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random and directed checks of fetch_sequencer
// against a PC/memory/execute environment and an address-sequence model.
module tb_fetch_sequencer;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        START;
   logic        HALT_REQ;
   logic        MEM_RD_REQ;
   logic        MEM_RD_ACK;
   logic [18:0] MEM_RDATA;
   logic [18:0] INSTR;
   logic        INSTR_VALID;
   logic        EXEC_DONE;
   logic        BRANCH_TAKEN;
   logic [18:0] BRANCH_TARGET;
   logic        LOAD_REG;
   logic [1:0]  LOAD_SELECT;
   logic        INC_PC;
   logic [18:0] PC_LOAD_ADDR;
   logic        HALTED;
   logic        FETCH_ERR;
   logic [2:0]  STATE;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          iv_at = 0;
   bit          noise = 1'b0;
   logic [18:0] pc    = '0;
   logic [18:0] exp_pc = '0;

   fetch_sequencer dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .START        (START),
      .HALT_REQ     (HALT_REQ),
      .MEM_RD_REQ   (MEM_RD_REQ),
      .MEM_RD_ACK   (MEM_RD_ACK),
      .MEM_RDATA    (MEM_RDATA),
      .INSTR        (INSTR),
      .INSTR_VALID  (INSTR_VALID),
      .EXEC_DONE    (EXEC_DONE),
      .BRANCH_TAKEN (BRANCH_TAKEN),
      .BRANCH_TARGET(BRANCH_TARGET),
      .LOAD_REG     (LOAD_REG),
      .LOAD_SELECT  (LOAD_SELECT),
      .INC_PC       (INC_PC),
      .PC_LOAD_ADDR (PC_LOAD_ADDR),
      .HALTED       (HALTED),
      .FETCH_ERR    (FETCH_ERR),
      .STATE        (STATE)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // external program counter obeying the command bus
   always @(posedge CLK) begin
      if (LOAD_SELECT == 2'b01) begin
         if (LOAD_REG)    pc <= PC_LOAD_ADDR;
         else if (INC_PC) pc <= pc + 19'd1;
         else             pc <= '0;
      end
   end

   function automatic logic [18:0] mem(input logic [18:0] a);
      return (a * 19'd7) ^ 19'h2A5A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic rnd_start();
      START = noise ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   // START from IDLE/HALT; returns at first FETCH cycle
   task automatic do_start();
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      chk("clr_state", STATE, 1);
      chk("clr_sel", LOAD_SELECT, 2'b01);
      chk("clr_ld", LOAD_REG, 0);
      chk("clr_inc", INC_PC, 0);
      chk("clr_req", MEM_RD_REQ, 0);
      @(negedge CLK);
      chk("start_pc", pc, 0);
      chk("start_err", FETCH_ERR, 0);
      chk("start_req", MEM_RD_REQ, 1);
      exp_pc = '0;
   endtask

   // one instruction from first FETCH cycle to the next boundary
   task automatic run_instr(input int ad, input int ed, input bit br,
                            input logic [18:0] tg, input bit hr);
      chk("fetch_state", STATE, 2);
      chk("fetch_pc", pc, exp_pc);
      HALT_REQ = hr;
      for (int i = 0; i < ad; i++) begin
         rnd_start();
         @(negedge CLK);
         HALT_REQ = 1'b0;
         chk("fetch_wait_req", MEM_RD_REQ, 1);
      end
      rnd_start();
      MEM_RD_ACK = 1'b1;
      MEM_RDATA  = mem(pc);
      @(negedge CLK);
      HALT_REQ   = 1'b0;
      MEM_RD_ACK = 1'b0;
      MEM_RDATA  = 19'($urandom);
      chk("iv_first", INSTR_VALID, 1);
      chk("instr", INSTR, mem(exp_pc));
      chk("exec_req", MEM_RD_REQ, 0);
      iv_at = cyc;
      for (int j = 0; j < ed; j++) begin
         EXEC_DONE    = 1'b0;
         BRANCH_TAKEN = 1'($urandom);
         rnd_start();
         @(negedge CLK);
         chk("iv_pulse", INSTR_VALID, 0);
         chk("exec_state", STATE, 3);
      end
      EXEC_DONE     = 1'b1;
      BRANCH_TAKEN  = br;
      BRANCH_TARGET = tg;
      rnd_start();
      @(negedge CLK);
      START         = 1'b0;
      EXEC_DONE     = 1'b0;
      BRANCH_TAKEN  = 1'($urandom);
      BRANCH_TARGET = 19'($urandom);
      chk("upd_state", STATE, 4);
      chk("upd_sel", LOAD_SELECT, 2'b01);
      chk("upd_ld", LOAD_REG, br);
      chk("upd_inc", INC_PC, !br);
      if (br) chk("upd_addr", PC_LOAD_ADDR, tg);
      exp_pc = br ? tg : 19'(exp_pc + 19'd1);
      @(negedge CLK);
      if (hr) begin
         chk("halt_state", STATE, 5);
         chk("halt_flag", HALTED, 1);
         chk("halt_pc", pc, exp_pc);
      end
   endtask

   initial begin
      int n;
      int prev;
      bit hr;
      RESET_N       = 1'b0;
      START         = 1'b0;
      HALT_REQ      = 1'b0;
      MEM_RD_ACK    = 1'b0;
      MEM_RDATA     = '0;
      EXEC_DONE     = 1'b0;
      BRANCH_TAKEN  = 1'b0;
      BRANCH_TARGET = '0;
      repeat (2) @(negedge CLK);
      chk("rst_state", STATE, 0);
      chk("rst_req", MEM_RD_REQ, 0);
      chk("rst_instr", INSTR, 0);
      chk("rst_iv", INSTR_VALID, 0);
      chk("rst_ld", LOAD_REG, 0);
      chk("rst_sel", LOAD_SELECT, 0);
      chk("rst_inc", INC_PC, 0);
      chk("rst_addr", PC_LOAD_ADDR, 0);
      chk("rst_halted", HALTED, 0);
      chk("rst_err", FETCH_ERR, 0);
      RESET_N = 1'b1;
      repeat (2) @(negedge CLK);
      chk("idle_hold", STATE, 0);

      // sequential, zero-wait
      do_start();
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         run_instr(0, 0, 1'b0, '0, 1'b0);
         if (k > 0) chk("iv_gap", iv_at - prev, 3);
         prev = iv_at;
      end
      chk("seq_pc", pc, 4);

      // branch
      run_instr(0, 0, 1'b1, 19'h00120, 1'b0);
      chk("br_pc", pc, 19'h120);
      run_instr(15, 0, 1'b0, '0, 1'b0);

      // wrap
      run_instr(0, 1, 1'b1, 19'h7FFFF, 1'b0);
      run_instr(1, 0, 1'b0, '0, 1'b0);
      chk("wrap_pc", pc, 0);
      chk("wrap_err", FETCH_ERR, 0);

      // halt at boundary
      run_instr(2, 1, 1'b0, '0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         chk("halt_sel", LOAD_SELECT, 0);
         chk("halt_cmd", {LOAD_REG, INC_PC}, 0);
      end
      chk("halt_pc_hold", pc, exp_pc);
      do_start();

      // fetch timeout
      n = 0;
      while (MEM_RD_REQ && n < 40) begin
         n++;
         @(negedge CLK);
      end
      chk("tmo_req_cycles", n, 16);
      chk("tmo_err", FETCH_ERR, 1);
      chk("tmo_halted", HALTED, 1);
      chk("tmo_state", STATE, 5);
      do_start();
      run_instr(0, 0, 1'b0, '0, 1'b0);

      // randomized run with spurious START during FETCH/EXEC
      noise = 1'b1;
      for (int k = 0; k < 40; k++) begin
         hr = ($urandom_range(0, 9) == 0);
         run_instr(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), 19'($urandom), hr);
         if (hr) do_start();
      end
      noise = 1'b0;
      chk("rnd_err", FETCH_ERR, 0);

      // async reset in the first EXEC cycle
      MEM_RD_ACK = 1'b1;
      MEM_RDATA  = mem(pc);
      @(negedge CLK);
      chk("pre_rst_iv", INSTR_VALID, 1);
      #2 RESET_N = 1'b0;
      #1;
      chk("arst_state", STATE, 0);
      chk("arst_iv", INSTR_VALID, 0);
      chk("arst_instr", INSTR, 0);
      chk("arst_req", MEM_RD_REQ, 0);
      chk("arst_cmd", {LOAD_REG, LOAD_SELECT, INC_PC}, 0);
      @(posedge CLK);
      #2 RESET_N = 1'b1;
      @(negedge CLK);
      chk("arst_idle", STATE, 0);
      chk("arst_ack_ign", INSTR, 0);
      MEM_RD_ACK = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
